cpu_mem_port: RTL and testbench
===============================

# cpu_mem_port

Request buffer and issue sequencer between the CPU core's load/store unit and the set-associative cache inside the DRAM-test master. Accepts core memory requests over a valid/ready handshake and queues them in order. Presents them one at a time to the cache as `cpu_req_type`, holding each until the cache's `cpu_result_type.ready`. Returns load data to the core.

## Interface
Parameters:
- `DEPTH`, 4: request queue entries; power of two, ≥2.
- `TIMEOUT`, 4095: cycles a cache request may wait before `err` sets.

Ports:
- `sys_clk` in 1: single clock, same domain as the cache.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: queue can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `rsp_valid` out 1: one-cycle pulse with load data.
- `rsp_rdata` out 32: load data, valid only with `rsp_valid`.
- `cache_req` out `cpu_req_type`: fields `addr[31:0]`, `data[31:0]`, `rw` (1 = write), `valid`.
- `cache_res` in `cpu_result_type`: fields `data[31:0]`, `ready`.
- `busy` out 1: queue non-empty or a cache request is outstanding.
- `err` out 1: sticky timeout flag.

## Operation
- Enqueue happens when `req_valid && req_ready`.
- `req_ready = !full`, computed from the registered count only. A pop in the same cycle does not open a slot, so a full queue never accepts a request.
- Stores are posted: no response is returned to the core. Loads produce exactly one `rsp_valid` pulse.
- Requests issue strictly in acceptance order, so read-after-write to the same address is ordered through the cache.
- State machine `IDLE`/`WAIT`:
  - `IDLE`: if the queue is non-empty, register the head entry into `cache_req` with `valid=1` and go to `WAIT`. Otherwise hold `valid=0`.
  - `WAIT`: hold all `cache_req` fields stable.
  - `WAIT` on `cache_res.ready=1`: pop the head, clear `valid`, and return to `IDLE`. If the request was a load, pulse `rsp_valid` and set `rsp_rdata = cache_res.data`, both registered.
- Any `cache_res.ready` seen in `IDLE` is ignored.
- Timeout counter:
  - Clears on entry to `WAIT` and increments each cycle in `WAIT`.
  - On reaching `TIMEOUT`, set `err=1`. `err` is sticky until `rst`.
  - The request keeps waiting; the counter saturates.
- Queue pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. The count is `log2(DEPTH)+1` bits. Simultaneous enqueue and pop leave the count unchanged.
- Reset mid-transaction: the queue empties, `cache_req.valid` drops, and the outstanding request is abandoned. The cache shares `rst`.

## Timing
- Reset values: `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `cache_req=0` (all fields), `busy=0`, `err=0`, state `IDLE`.
- Request accepted into an idle, empty block at edge N: `cache_req.valid=1` after edge N+1.
- `cache_res.ready` sampled at edge M:
  - `rsp_valid` high during cycle M..M+1 (after edge M).
  - `cache_req.valid=0` after edge M.
  - The next request's `valid` rises after edge M+1, giving at least one `valid`-low cycle between cache requests.
- Best-case throughput: one request per 2 cycles plus cache latency.
- `busy` is combinational from the count and state.

## Structure
- Shared package `mem_pkg`: `cpu_req_type` and `cpu_result_type` (the same types the cache consumes), plus the address and data width constants.
- Sub-module `req_fifo`: synchronous FIFO of `{we, addr, wdata}` with `DEPTH` entries, wrapping pointers, and `full`/`empty`/`count` outputs.
- `cpu_mem_port` instantiates `req_fifo` and contains the state machine, the timeout counter, and the response register.

## Test plan
- Single load to addr `0x0000_0040` with the cache answering `data=0xDEAD_BEEF` 5 cycles after `valid`:
  - `cache_req.rw=0`, `addr=0x40`.
  - One `rsp_valid` pulse with `0xDEADBEEF`.
  - `busy` low again afterwards.
- Store `0x1234_5678` to `0x100`, then load from `0x100` in back-to-back cycles:
  - Cache sees the write first (`rw=1`, `data=0x12345678`), then the read.
  - Exactly one `rsp_valid`.
- Issue 4 stores while the cache stalls `ready`:
  - `req_ready=0` after the 4th accept.
  - A 5th request held on `req_valid` is accepted only in the cycle after the first pop.
  - All 4 stores reach the cache in order.
- Cache never asserts `ready`, with `TIMEOUT=16`:
  - `err=1` exactly 16 cycles after `WAIT` entry.
  - `cache_req` stays stable.
  - A later `ready` completes the request; `err` remains 1.
- Assert `rst` while in `WAIT` with 3 entries queued:
  - Immediately: `cache_req.valid=0`, `busy=0`, `req_ready=1`.
  - After release: no stale request reaches the cache.
- Spurious `cache_res.ready` pulses while `IDLE` with an empty queue: no `rsp_valid` and no state change.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-side types for the DRAM-test master.
// Holds the CPU/cache request and result structs, the bus widths, the
// request-queue entry format and the issue-sequencer state encoding.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Request presented to the set-associative cache.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw;     // 1 = write
        logic              valid;
    } cpu_req_type;

    // Cache completion.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ready;
    } cpu_result_type;

    // One queued core request.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } port_state_e;

endpackage

// File: rtl/req_fifo.sv
// Synchronous in-order request queue.
// Ports: sys_clk/rst (async active-high), push/push_entry enqueue,
// pop dequeues the head, head is the oldest entry, full/empty/count status.
module req_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     push,
    input  req_entry_t               push_entry,
    input  logic                     pop,
    output req_entry_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    req_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries behind a valid count are ever read.
    always_ff @(posedge sys_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/cpu_mem_port.sv
// Request buffer and issue sequencer between the load/store unit and the cache.
// Ports: sys_clk/rst; core side req_valid/req_ready/req_we/req_addr/req_wdata,
// rsp_valid/rsp_rdata for loads; cache side cache_req/cache_res;
// status busy (combinational) and sticky timeout err.
module cpu_mem_port
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output cpu_req_type         cache_req,
    input  cpu_result_type      cache_res,
    output logic                busy,
    output logic                err
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    port_state_e       state_q, state_d;
    cpu_req_type       cache_req_q, cache_req_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              err_q, err_d;

    req_entry_t        push_entry;
    req_entry_t        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_pop;

    assign push_entry = '{we: req_we, addr: req_addr, wdata: req_wdata};

    req_fifo #(
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .push       (req_valid && req_ready),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Ready comes from the registered count only, so a same-cycle pop never opens a slot.
    assign req_ready = !fifo_full;
    assign busy      = (fifo_count != '0) || (state_q == WAIT);
    assign cache_req = cache_req_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err       = err_q;

    // Issue sequencer, timeout counter and load response.
    always_comb begin
        state_d     = state_q;
        cache_req_d = cache_req_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    cache_req_d.addr  = head.addr;
                    cache_req_d.data  = head.wdata;
                    cache_req_d.rw    = head.we;
                    cache_req_d.valid = 1'b1;
                    tmo_cnt_d         = '0;
                    state_d           = WAIT;
                end
            end
            WAIT: begin
                // Counter saturates at TIMEOUT; the request keeps waiting.
                if (tmo_cnt_q != TMO_W'(TIMEOUT)) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
                if (tmo_cnt_d == TMO_W'(TIMEOUT)) begin
                    err_d = 1'b1;
                end
                if (cache_res.ready) begin
                    fifo_pop          = 1'b1;
                    cache_req_d.valid = 1'b0;
                    state_d           = IDLE;
                    if (!cache_req_q.rw) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = cache_res.data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cache_req_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cache_req_q <= cache_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_cpu_mem_port.sv
// Self-checking bench for cpu_mem_port: directed scenarios plus random traffic,
// checked every cycle against a transaction-level queue model of the port.
module tb_cpu_mem_port;
    import mem_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic           sys_clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_we = 1'b0;
    logic [31:0]    req_addr = '0;
    logic [31:0]    req_wdata = '0;
    logic           rsp_valid;
    logic [31:0]    rsp_rdata;
    cpu_req_type    cache_req;
    cpu_result_type cache_res = '0;
    logic           busy;
    logic           err;

    cpu_mem_port #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .cache_req (cache_req),
        .cache_res (cache_res),
        .busy      (busy),
        .err       (err)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int          cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Inputs as seen just before each rising edge.
    logic        c_rst = 1'b1, c_vld = 1'b0, c_we = 1'b0, c_crdy = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, c_cdata = '0;

    always @(negedge sys_clk) begin
        #3;
        c_rst   = rst;
        c_vld   = req_valid;
        c_we    = req_we;
        c_addr  = req_addr;
        c_wdata = req_wdata;
        c_crdy  = cache_res.ready;
        c_cdata = cache_res.data;
    end

    // Reference model: in-order list of accepted requests, head is the one at the cache.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          acc;
    } m_ent_t;

    m_ent_t      mq[$];
    bit          outst = 0;
    bit          exp_rsp = 0;
    bit          exp_err = 0;
    logic [31:0] exp_rdata = '0;
    int          issue_cyc = 0;
    int          last_pop = -10;
    int          last_acc = -1;
    int          rsp_cnt = 0;
    logic [31:0] last_rsp = '0;

    always @(posedge sys_clk) begin
        bit     acc;
        m_ent_t e;
        #1;
        cyc++;
        if (c_rst) begin
            mq.delete();
            outst   = 0;
            exp_rsp = 0;
            exp_err = 0;
            last_pop = -10;
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_cache_valid", 32'(cache_req.valid), 32'd0);
            chk("rst_cache_addr", cache_req.addr, 32'd0);
            chk("rst_cache_data", cache_req.data, 32'd0);
            chk("rst_cache_rw", 32'(cache_req.rw), 32'd0);
        end else begin
            acc     = c_vld && (mq.size() < DEPTH);
            exp_rsp = 0;
            if (outst) begin
                if (cyc - issue_cyc >= int'(TIMEOUT)) exp_err = 1;
                if (c_crdy) begin
                    e        = mq.pop_front();
                    outst    = 0;
                    last_pop = cyc;
                    if (!e.we) begin
                        exp_rsp   = 1;
                        exp_rdata = c_cdata;
                    end
                end
            end
            if (acc) begin
                mq.push_back('{c_we, c_addr, c_wdata, cyc});
                last_acc = cyc;
            end
            // Issue one edge after acceptance and never on the edge of a pop.
            if (!outst && mq.size() > 0 && mq[0].acc < cyc && last_pop < cyc) begin
                outst     = 1;
                issue_cyc = cyc;
            end
            chk("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
            chk("busy", 32'(busy), 32'(mq.size() > 0));
            chk("cache_valid", 32'(cache_req.valid), 32'(outst));
            if (outst) begin
                chk("cache_addr", cache_req.addr, mq[0].addr);
                chk("cache_data", cache_req.data, mq[0].wdata);
                chk("cache_rw", 32'(cache_req.rw), 32'(mq[0].we));
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            if (exp_rsp) chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("err", 32'(err), 32'(exp_err));
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                last_rsp = rsp_rdata;
            end
        end
    end

    // Behavioural cache: fixed or random latency, backing store, optional spurious ready.
    int          lat_fix = 0;
    bit          spur_en = 0;
    int          w_cnt = 0;
    int          cur_lat = 1;
    logic [31:0] cmem [logic [31:0]];

    always @(posedge sys_clk) begin
        #2;
        if (rst) begin
            cache_res.ready = 1'b0;
            w_cnt = 0;
        end else if (cache_req.valid) begin
            if (w_cnt == 0) cur_lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6));
            w_cnt++;
            if (w_cnt >= cur_lat) begin
                cache_res.ready = 1'b1;
                if (cache_req.rw) begin
                    cmem[cache_req.addr] = cache_req.data;
                    cache_res.data = $urandom;
                end else if (cmem.exists(cache_req.addr)) begin
                    cache_res.data = cmem[cache_req.addr];
                end else begin
                    cache_res.data = {cache_req.addr[15:0], 16'hC0DE};
                end
                w_cnt = 0;
            end else begin
                cache_res.ready = 1'b0;
                cache_res.data  = $urandom;
            end
        end else begin
            w_cnt = 0;
            cache_res.ready = spur_en && ($urandom_range(0, 2) == 0);
            cache_res.data  = $urandom;
        end
    end

    task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 200; i++) begin
            @(posedge sys_clk);
            #2;
            if (last_acc == cyc) return;
        end
        chk("send_accept_bound", 32'(last_acc), 32'(cyc));
        req_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic wait_idle();
        req_valid = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge sys_clk);
            #2;
            if (!busy && !cache_req.valid) return;
        end
        chk("idle_bound", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int p0;
        repeat (3) @(posedge sys_clk);
        #4;
        rst = 1'b0;

        // Single load with a 5-cycle cache.
        cmem[32'h40] = 32'hDEAD_BEEF;
        lat_fix = 5;
        rsp_cnt = 0;
        send(1'b0, 32'h40, 32'h0);
        wait_idle();
        idle_cycles(2);
        chk("load_rsp_count", 32'(rsp_cnt), 32'd1);
        chk("load_rsp_data", last_rsp, 32'hDEAD_BEEF);
        chk("load_busy_after", 32'(busy), 32'd0);

        // Store then load to the same address, back to back.
        lat_fix = 0;
        rsp_cnt = 0;
        send(1'b1, 32'h100, 32'h1234_5678);
        send(1'b0, 32'h100, 32'h0);
        wait_idle();
        idle_cycles(2);
        chk("raw_rsp_count", 32'(rsp_cnt), 32'd1);
        chk("raw_rsp_data", last_rsp, 32'h1234_5678);

        // Fill the queue behind a stalled cache.
        lat_fix = 12;
        for (int i = 0; i < 4; i++) send(1'b1, 32'h200 + 32'(4 * i), $urandom);
        req_valid = 1'b0;
        chk("full_req_ready", 32'(req_ready), 32'd0);
        send(1'b1, 32'h210, $urandom);
        chk("fifth_accept_after_pop", 32'(last_acc), 32'(last_pop + 1));
        wait_idle();

        // Random traffic with spurious ready pulses.
        lat_fix = 0;
        spur_en = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1)
                send(1'(($urandom_range(0, 1))), 32'($urandom_range(0, 15)) << 2, $urandom);
            else
                idle_cycles(1);
        end
        wait_idle();

        // Spurious ready while idle and empty.
        rsp_cnt = 0;
        idle_cycles(30);
        chk("spurious_rsp_count", 32'(rsp_cnt), 32'd0);
        chk("spurious_busy", 32'(busy), 32'd0);
        spur_en = 0;

        // Reset while a request waits with three entries queued.
        lat_fix = 40;
        for (int i = 0; i < 3; i++) send(1'b1, 32'h300 + 32'(4 * i), $urandom);
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_cache_valid", 32'(cache_req.valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        @(posedge sys_clk);
        #4;
        rst = 1'b0;
        lat_fix = 0;
        idle_cycles(5);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0)
                send(1'(($urandom_range(0, 1))), 32'($urandom_range(0, 15)) << 2, $urandom);
            else
                idle_cycles(1);
        end
        wait_idle();

        // Timeout: a slow cache sets err after exactly TIMEOUT cycles in WAIT.
        lat_fix = 30;
        rsp_cnt = 0;
        send(1'b0, 32'h80, 32'h0);
        req_valid = 1'b0;
        p0 = cyc;
        for (int i = 0; i < 60; i++) begin
            if (err === 1'b1) break;
            @(posedge sys_clk);
            #2;
        end
        chk("timeout_latency", 32'(cyc - issue_cyc), 32'(TIMEOUT));
        chk("timeout_not_instant", 32'(cyc > p0), 32'd1);
        wait_idle();
        idle_cycles(3);
        chk("timeout_rsp_count", 32'(rsp_cnt), 32'd1);
        chk("err_sticky", 32'(err), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
